bcd2bin: RTL and testbench

//   Sequential BCD-to-binary converter; the inverse of the bin2bcd double-dabble unit.

---
 rtl/bcd2bin_if.sv | 32 +++
 rtl/bcd2bin.sv | 129 ++++++++++++
 tb/tb_bcd2bin.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_if.sv
// Handshake and data bundle for the bcd2bin converter.
// The master side issues start/bcd. The slave (converter) side returns ready,
// done_tick, bin and err.
interface bcd2bin_if #(
    parameter int DIGITS = 11,
    parameter int BIN_W  = 37
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ready;
    logic                  done_tick;
    logic [BIN_W-1:0]      bin;
    logic                  err;

    modport master (
        output start,
        output bcd,
        input  ready,
        input  done_tick,
        input  bin,
        input  err
    );

    modport slave (
        input  start,
        input  bcd,
        output ready,
        output done_tick,
        output bin,
        output err
    );
endinterface

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Each OP cycle shifts {bcd_reg, bin_w} right by one bit. It then subtracts 3
// from every BCD nibble that has reached 8 or more. After BIN_W steps, bin_w
// holds the binary value. Inputs with a digit above 9 are rejected at once:
// the block goes straight to DONE with err set.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | ready=1, waiting for start; checks the digits and loads work regs
//   S_OP   | one shift/adjust step per cycle; down-counter cnt runs BIN_W..0
//   S_DONE | done_tick=1 for one cycle; bin/err already hold the new result
module bcd2bin #(
    parameter int DIGITS = 11,
    parameter int BIN_W  = 37
) (
    input  logic       clk,
    input  logic       rst,
    bcd2bin_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OP   = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_reg, bcd_nxt;
    logic [BIN_W-1:0]   bin_w, bin_w_nxt;
    logic [BIN_W-1:0]   bin_r, bin_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               err_r, err_nxt;

    logic               bcd_bad;
    logic [BCD_W-1:0]   bcd_sh;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BIN_W-1:0]   bin_sh;

    // Flag an incoming value that contains any digit outside 0..9
    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: logical right shift, then -3 on nibbles >= 8
    always_comb begin
        {bcd_sh, bin_sh} = {bcd_reg, bin_w} >> 1;
        bcd_adj = bcd_sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd8) begin
                bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and datapath update selection
    always_comb begin
        state_nxt = state;
        bcd_nxt   = bcd_reg;
        bin_w_nxt = bin_w;
        cnt_nxt   = cnt;
        bin_nxt   = bin_r;
        err_nxt   = err_r;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bcd_bad) begin
                        err_nxt   = 1'b1;
                        bin_nxt   = '0;
                        state_nxt = S_DONE;
                    end else begin
                        bcd_nxt   = bus.bcd;
                        bin_w_nxt = '0;
                        cnt_nxt   = CNT_W'(BIN_W);
                        state_nxt = S_OP;
                    end
                end
            end
            S_OP: begin
                bcd_nxt   = bcd_adj;
                bin_w_nxt = bin_sh;
                cnt_nxt   = cnt - 1'b1;
                if (cnt_nxt == '0) begin
                    bin_nxt   = bin_sh;
                    err_nxt   = 1'b0;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                // The unused encoding recovers to IDLE
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, work registers and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bcd_reg <= '0;
            bin_w   <= '0;
            cnt     <= '0;
            bin_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            bcd_reg <= bcd_nxt;
            bin_w   <= bin_w_nxt;
            cnt     <= cnt_nxt;
            bin_r   <= bin_nxt;
            err_r   <= err_nxt;
        end
    end

    assign bus.ready     = (state == S_IDLE);
    assign bus.done_tick = (state == S_DONE);
    assign bus.bin       = bin_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin. Expected results come from a decimal model:
// the digits are accumulated as val = val*10 + digit, and any digit above 9
// marks the input as an error.
module tb_bcd2bin;
    localparam int DIGITS = 11;
    localparam int BIN_W  = 37;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int LIMIT  = BIN_W + 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    bcd2bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_val(input logic [BCD_W-1:0] v);
        logic [63:0] acc = 0;
        for (int i = DIGITS - 1; i >= 0; i--) acc = acc * 10 + 64'(v[4*i +: 4]);
        return acc;
    endfunction

    function automatic logic model_bad(input logic [BCD_W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [BCD_W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) chk_eq({tag, ".ready_timeout"}, 64'(bus.ready), 64'd1);
    endtask

    // Run one conversion, optionally pulsing start with a different bcd at OP cycle poke_at
    task automatic run_conv(input string tag, input logic [BCD_W-1:0] v,
                            input logic [63:0] exp_bin, input logic exp_err, input int poke_at);
        int lat, rdy_low;
        logic stable;
        logic [BIN_W-1:0] bin0;
        wait_ready(tag);
        bus.start = 1'b1;
        bus.bcd   = v;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.bcd   = rand_word();
        bin0    = bus.bin;
        stable  = 1'b1;
        lat     = 0;
        rdy_low = bus.ready ? 0 : 1;
        while (!bus.done_tick && lat < LIMIT) begin
            if (lat == poke_at) begin
                bus.start = 1'b1;
                bus.bcd   = rand_word();
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (!bus.ready) rdy_low++;
            if (!bus.done_tick && bus.bin !== bin0) stable = 1'b0;
        end
        bus.start = 1'b0;
        chk_eq({tag, ".latency"}, 64'(lat), exp_err ? 64'd0 : 64'(BIN_W));
        chk_eq({tag, ".ready_low"}, 64'(rdy_low), 64'(lat + 1));
        chk_eq({tag, ".bin"}, 64'(bus.bin), exp_bin);
        chk_eq({tag, ".err"}, 64'(bus.err), 64'(exp_err));
        chk_eq({tag, ".bin_stable"}, 64'(stable), 64'd1);
        @(posedge clk); #1;
        chk_eq({tag, ".done_one_cycle"}, 64'(bus.done_tick), 64'd0);
        chk_eq({tag, ".ready_back"}, 64'(bus.ready), 64'd1);
    endtask

    initial begin
        logic [BCD_W-1:0] v;
        logic [63:0] ev;
        logic eb;
        int n, rdy, dn;

        bus.start = 1'b0;
        bus.bcd   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset.ready", 64'(bus.ready), 64'd1);
        chk_eq("reset.done", 64'(bus.done_tick), 64'd0);
        chk_eq("reset.bin", 64'(bus.bin), 64'd0);
        chk_eq("reset.err", 64'(bus.err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_conv("zero", '0, 64'd0, 1'b0, -1);
        run_conv("max", {DIGITS{4'h9}}, 64'h17_4876_E7FF, 1'b0, -1);
        run_conv("typ", 44'h0_0000_0012_345, 64'h3039, 1'b0, -1);

        // Reset while OP is running: aborts with no done_tick and clears the result
        wait_ready("rst");
        bus.start = 1'b1;
        bus.bcd   = 44'h0_0000_0012_345;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done_tick) dn++;
        end
        rst = 1'b1;
        #1;
        chk_eq("rst.ready", 64'(bus.ready), 64'd1);
        chk_eq("rst.bin", 64'(bus.bin), 64'd0);
        chk_eq("rst.err", 64'(bus.err), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done_tick) dn++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < BIN_W + 3; i++) begin
            @(posedge clk); #1;
            if (bus.done_tick) dn++;
        end
        chk_eq("rst.no_done", 64'(dn), 64'd0);
        run_conv("after_rst", 44'h8, 64'd8, 1'b0, -1);

        run_conv("invalid", 44'h0_0000_0000_A000, 64'd0, 1'b1, -1);
        run_conv("valid7", 44'h7, 64'd7, 1'b0, -1);
        run_conv("poke", 44'h0_0009_8765_432, 64'd98765432, 1'b0, 10);

        // Back-to-back: start held high through DONE
        wait_ready("b2b");
        bus.start = 1'b1;
        bus.bcd   = 44'h0_0000_0000_321;
        n = 0;
        while (!bus.done_tick && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("b2b.first_done", 64'(bus.done_tick), 64'd1);
        n = 0;
        rdy = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (bus.ready) rdy++;
        end while (!bus.done_tick && n < LIMIT);
        bus.start = 1'b0;
        chk_eq("b2b.gap", 64'(n), 64'(BIN_W + 2));
        chk_eq("b2b.ready_cycles", 64'(rdy), 64'd1);
        chk_eq("b2b.bin", 64'(bus.bin), 64'd321);
        @(posedge clk); #1;

        // Random digits, some inputs carrying one out-of-range nibble
        for (int t = 0; t < 30; t++) begin
            v = '0;
            for (int d = 0; d < DIGITS; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) v[4*$urandom_range(0, DIGITS - 1) +: 4] = 4'($urandom_range(10, 15));
            eb = model_bad(v);
            ev = eb ? 64'd0 : model_val(v);
            run_conv($sformatf("rnd%0d", t), v, ev, eb, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
